// File: rtl/fetch_pc_unit.sv
// Program counter and fetch sequencer feeding the 9-bit instruction ROM.
// Handles start/halt, stall, branch/jump redirects and a call/return stack.
module fetch_pc_unit #(
    parameter logic [7:0] START_ADDR = 8'd0,
    parameter logic [7:0] LAST_ADDR  = 8'd140,
    parameter int         RAS_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stall,
    input  logic       halt_req,
    input  logic       br_taken,
    input  logic       jump,
    input  logic       call,
    input  logic       ret,
    input  logic [7:0] target,
    output logic [7:0] prog_ctr,
    output logic       fetch_valid,
    output logic       done,
    output logic       ras_err
);

    localparam int IW  = $clog2(RAS_DEPTH);
    localparam int SPW = IW + 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(RAS_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    state_t         state, state_nx;
    logic [7:0]     pc_nx;
    logic [7:0]     pc_inc;
    logic [SPW-1:0] sp, sp_nx;
    logic [IW-1:0]  top_idx;
    logic           err_nx;
    logic           push;
    logic [7:0]     stack [RAS_DEPTH];

    assign pc_inc  = prog_ctr + 8'd1;
    assign top_idx = IW'(sp - SPW'(1));

    assign fetch_valid = (state == RUN) && !stall;
    assign done        = (state == HALT);

    always_comb begin
        state_nx = state;
        pc_nx    = prog_ctr;
        sp_nx    = sp;
        err_nx   = ras_err;
        push     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    pc_nx    = START_ADDR;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_nx = HALT;
                end else if (stall) begin
                    pc_nx = prog_ctr;
                end else if (ret) begin
                    // ret outranks call when both arrive together
                    if (sp == '0) begin
                        err_nx = 1'b1;
                        pc_nx  = pc_inc;
                    end else begin
                        pc_nx = stack[top_idx];
                        sp_nx = sp - SPW'(1);
                    end
                end else if (call) begin
                    pc_nx = target;
                    if (sp == SP_FULL) begin
                        err_nx = 1'b1;
                    end else begin
                        push  = 1'b1;
                        sp_nx = sp + SPW'(1);
                    end
                end else if (jump || br_taken) begin
                    pc_nx = target;
                end else if (prog_ctr == LAST_ADDR) begin
                    state_nx = HALT;
                end else begin
                    pc_nx = pc_inc;
                end
            end
            HALT: begin
                if (start) begin
                    state_nx = RUN;
                    pc_nx    = START_ADDR;
                    sp_nx    = '0;
                    err_nx   = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            prog_ctr <= START_ADDR;
            sp       <= '0;
            ras_err  <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            state    <= state_nx;
            prog_ctr <= pc_nx;
            sp       <= sp_nx;
            ras_err  <= err_nx;
            if (push) begin
                stack[sp[IW-1:0]] <= pc_inc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: vector table plus a free-run
// sequence, with expected outputs queued per cycle and checked in order.
module tb_fetch_pc_unit;

    typedef enum logic [3:0] {
        NOP, START, JMP, BR, BR_STALL, CALL, RET,
        CALLRET, HALT_STALL, HALT_RQ, RST
    } op_t;

    typedef struct {
        op_t        op;
        logic [7:0] tg;
        logic [7:0] pc;
        logic       fv;
        logic       dn;
        logic       er;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stall;
    logic       halt_req;
    logic       br_taken;
    logic       jump;
    logic       call;
    logic       ret;
    logic [7:0] target;
    logic [7:0] prog_ctr;
    logic       fetch_valid;
    logic       done;
    logic       ras_err;

    int   n_tests;
    int   n_fail;
    int   n_step;
    vec_t tbl[$];
    vec_t sb[$];

    fetch_pc_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stall      (stall),
        .halt_req   (halt_req),
        .br_taken   (br_taken),
        .jump       (jump),
        .call       (call),
        .ret        (ret),
        .target     (target),
        .prog_ctr   (prog_ctr),
        .fetch_valid(fetch_valid),
        .done       (done),
        .ras_err    (ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(op_t op, int tg, int pc,
                                bit fv, bit dn, bit er);
        vec_t v;
        v.op = op;
        v.tg = 8'(tg);
        v.pc = 8'(pc);
        v.fv = fv;
        v.dn = dn;
        v.er = er;
        return v;
    endfunction

    task automatic cmp(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL step %0d %s: got %0d, expected %0d",
                     n_step, name, act, exp);
        end
    endtask

    task automatic check_out();
        vec_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL step %0d scoreboard: got empty, expected entry",
                     n_step);
        end else begin
            e = sb.pop_front();
            cmp("prog_ctr", int'(prog_ctr), int'(e.pc));
            cmp("fetch_valid", int'(fetch_valid), int'(e.fv));
            cmp("done", int'(done), int'(e.dn));
            cmp("ras_err", int'(ras_err), int'(e.er));
        end
    endtask

    task automatic step(vec_t v);
        @(negedge clk);
        reset    = 1'b0;
        start    = 1'b0;
        stall    = 1'b0;
        halt_req = 1'b0;
        br_taken = 1'b0;
        jump     = 1'b0;
        call     = 1'b0;
        ret      = 1'b0;
        target   = v.tg;
        case (v.op)
            START:      start = 1'b1;
            JMP:        jump = 1'b1;
            BR:         br_taken = 1'b1;
            BR_STALL:   begin br_taken = 1'b1; stall = 1'b1; end
            CALL:       call = 1'b1;
            RET:        ret = 1'b1;
            CALLRET:    begin call = 1'b1; ret = 1'b1; end
            HALT_STALL: begin halt_req = 1'b1; stall = 1'b1; end
            HALT_RQ:    halt_req = 1'b1;
            RST:        reset = 1'b1;
            default:    ;
        endcase
        sb.push_back(v);
        #1;
        check_out();
        n_step++;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        n_step   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        stall    = 1'b0;
        halt_req = 1'b0;
        br_taken = 1'b0;
        jump     = 1'b0;
        call     = 1'b0;
        ret      = 1'b0;
        target   = 8'd0;
        repeat (2) @(posedge clk);

        // op, target | expected pc, fetch_valid, done, ras_err
        tbl.push_back(mk(NOP,        0,   0, 0, 0, 0));
        tbl.push_back(mk(START,      0,   0, 0, 0, 0));
        tbl.push_back(mk(NOP,        0,   0, 1, 0, 0));
        tbl.push_back(mk(NOP,        0,   1, 1, 0, 0));
        tbl.push_back(mk(NOP,        0,   2, 1, 0, 0));
        tbl.push_back(mk(JMP,       30,   3, 1, 0, 0));
        tbl.push_back(mk(BR_STALL,  39,  30, 0, 0, 0));
        tbl.push_back(mk(BR,        39,  30, 1, 0, 0));
        tbl.push_back(mk(JMP,       10,  39, 1, 0, 0));
        tbl.push_back(mk(CALL,      70,  10, 1, 0, 0));
        tbl.push_back(mk(JMP,       75,  70, 1, 0, 0));
        tbl.push_back(mk(RET,        0,  75, 1, 0, 0));
        tbl.push_back(mk(START,      0,  11, 1, 0, 0));
        tbl.push_back(mk(JMP,       50,  12, 1, 0, 0));
        tbl.push_back(mk(HALT_STALL, 0,  50, 0, 0, 0));
        tbl.push_back(mk(NOP,        0,  50, 0, 1, 0));
        tbl.push_back(mk(START,      0,  50, 0, 1, 0));
        tbl.push_back(mk(CALL,     100,   0, 1, 0, 0));
        tbl.push_back(mk(CALL,     110, 100, 1, 0, 0));
        tbl.push_back(mk(CALL,     120, 110, 1, 0, 0));
        tbl.push_back(mk(CALL,     130, 120, 1, 0, 0));
        tbl.push_back(mk(CALL,     140, 130, 1, 0, 0));
        tbl.push_back(mk(RET,        0, 140, 1, 0, 1));
        tbl.push_back(mk(RET,        0, 121, 1, 0, 1));
        tbl.push_back(mk(RET,        0, 111, 1, 0, 1));
        tbl.push_back(mk(RET,        0, 101, 1, 0, 1));
        tbl.push_back(mk(RET,        0,   1, 1, 0, 1));
        tbl.push_back(mk(CALLRET,  200,   2, 1, 0, 1));
        tbl.push_back(mk(CALL,      20,   3, 1, 0, 1));
        tbl.push_back(mk(CALLRET,   90,  20, 1, 0, 1));
        tbl.push_back(mk(CALL,      60,   4, 1, 0, 1));
        tbl.push_back(mk(HALT_RQ,    0,  60, 1, 0, 1));
        tbl.push_back(mk(NOP,        0,  60, 0, 1, 1));
        tbl.push_back(mk(START,      0,  60, 0, 1, 1));
        tbl.push_back(mk(RET,        0,   0, 1, 0, 0));
        tbl.push_back(mk(RST,        0,   1, 1, 0, 1));
        tbl.push_back(mk(NOP,        0,   0, 0, 0, 0));
        tbl.push_back(mk(START,      0,   0, 0, 0, 0));
        tbl.push_back(mk(JMP,      250,   0, 1, 0, 0));
        tbl.push_back(mk(NOP,        0, 250, 1, 0, 0));
        tbl.push_back(mk(JMP,      255, 251, 1, 0, 0));
        tbl.push_back(mk(NOP,        0, 255, 1, 0, 0));
        tbl.push_back(mk(NOP,        0,   0, 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // free run from START_ADDR to the last address, then restart
        step(mk(HALT_RQ, 0, 1, 1, 0, 0));
        step(mk(NOP,     0, 1, 0, 1, 0));
        step(mk(START,   0, 1, 0, 1, 0));
        for (int a = 0; a <= 140; a++) begin
            step(mk(NOP, 0, a, 1, 0, 0));
        end
        step(mk(NOP,   0, 140, 0, 1, 0));
        step(mk(NOP,   0, 140, 0, 1, 0));
        step(mk(START, 0, 140, 0, 1, 0));
        step(mk(NOP,   0,   0, 1, 0, 0));
        step(mk(NOP,   0,   1, 1, 0, 0));

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard drain: got %0d left, expected 0",
                     sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
